dmem_port_arbiter: RTL and testbench

//  Shares the single data-memory port between NUM_REQ requesters (the LSU read/write unit, a second

---
 rtl/dmem_port_arbiter_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_rr_pick.sv | 28 ++
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: request slot layout,
// default requester count and arbiter state encoding.
package dmem_port_arbiter_pkg;

  typedef logic [31:0] word32_t;

  typedef struct packed {
    logic    we;
    word32_t addr;
    word32_t data;
  } dmem_req_t;

  localparam int unsigned NUM_DMEM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_e;

endpackage

// File: rtl/dmem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of valid_i at or after
// rr_ptr_i, wrapping around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  int unsigned j;

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (32'(rr_ptr_i) + i) % NUM_REQ;
      if (!any_o && valid_i[IDX_W'(j)]) begin
        any_o = 1'b1;
        idx_o = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between NUM_REQ pulse/done requesters using a
// pending slot per requester and round-robin grant, one access at a time.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_DMEM_REQ,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic [NUM_REQ-1:0]       req_read_i,
  input  logic [NUM_REQ-1:0]       req_write_i,
  input  logic [NUM_REQ-1:0][31:0] req_addr_i,
  input  logic [NUM_REQ-1:0][31:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_done_o,
  output logic [31:0]              req_rd_data_o,
  input  logic [31:0]              dmem_rd_data_i,
  input  logic                     dmem_done_i,
  output logic                     dmem_read_o,
  output logic                     dmem_write_o,
  output logic [31:0]              dmem_addr_o,
  output logic [31:0]              dmem_data_o,
  output logic                     busy_o,
  output logic                     err_o
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] valid_q, valid_d, keep;
  dmem_req_t          slot_q [NUM_REQ];
  dmem_req_t          slot_d [NUM_REQ];
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               err_q, err_d;
  logic               done_hit;
  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  // Clears happen before the next grant is chosen, so a flushed or completed
  // slot is never re-picked on the same edge.
  always_comb begin
    done_hit = (state_q == ST_WAIT) && dmem_done_i;
    keep     = valid_q;
    if (flush_i) begin
      keep = '0;
      if (state_q != ST_IDLE) keep[grant_q] = valid_q[grant_q];
    end
    if (done_hit) keep[grant_q] = 1'b0;
    rr_ptr_d = rr_ptr_q;
    if (done_hit) rr_ptr_d = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + 1'b1;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .valid_i  (keep),
    .rr_ptr_i (rr_ptr_d),
    .any_o    (pick_any),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    valid_d = keep;
    slot_d  = slot_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done_hit) begin
          if (pick_any) begin
            grant_d = pick_idx;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe landing on a slot cleared this edge is a legal capture.
    for (int unsigned m = 0; m < NUM_REQ; m++) begin
      if (req_read_i[m] || req_write_i[m]) begin
        if ((req_read_i[m] && req_write_i[m]) || keep[m]) begin
          err_d = 1'b1;
        end else begin
          valid_d[m]     = 1'b1;
          slot_d[m].we   = req_write_i[m];
          slot_d[m].addr = req_addr_i[m];
          slot_d[m].data = req_data_i[m];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= ST_IDLE;
      valid_q  <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
      for (int unsigned m = 0; m < NUM_REQ; m++) slot_q[m] <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
      slot_q   <= slot_d;
    end
  end

  always_comb begin
    req_done_o = '0;
    if (done_hit) req_done_o[grant_q] = 1'b1;
    req_rd_data_o = done_hit ? dmem_rd_data_i : '0;
    dmem_read_o   = (state_q == ST_ISSUE) && !slot_q[grant_q].we;
    dmem_write_o  = (state_q == ST_ISSUE) && slot_q[grant_q].we;
    dmem_addr_o   = slot_q[grant_q].addr;
    dmem_data_o   = slot_q[grant_q].data;
    busy_o        = (state_q != ST_IDLE);
    err_o         = err_q;
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by
// randomized traffic compared cycle by cycle against a transaction-level model.
module tb_dmem_port_arbiter;

  localparam int unsigned N = 2;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              flush_i;
  logic [N-1:0]      req_read_i;
  logic [N-1:0]      req_write_i;
  logic [N-1:0][31:0] req_addr_i;
  logic [N-1:0][31:0] req_data_i;
  logic [N-1:0]      req_done_o;
  logic [31:0]       req_rd_data_o;
  logic [31:0]       dmem_rd_data_i;
  logic              dmem_done_i;
  logic              dmem_read_o;
  logic              dmem_write_o;
  logic [31:0]       dmem_addr_o;
  logic [31:0]       dmem_data_o;
  logic              busy_o;
  logic              err_o;

  int tests_run    = 0;
  int tests_failed = 0;

  dmem_port_arbiter #(.NUM_REQ(N)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .flush_i        (flush_i),
    .req_read_i     (req_read_i),
    .req_write_i    (req_write_i),
    .req_addr_i     (req_addr_i),
    .req_data_i     (req_data_i),
    .req_done_o     (req_done_o),
    .req_rd_data_o  (req_rd_data_o),
    .dmem_rd_data_i (dmem_rd_data_i),
    .dmem_done_i    (dmem_done_i),
    .dmem_read_o    (dmem_read_o),
    .dmem_write_o   (dmem_write_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_data_o    (dmem_data_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: pending requests per requester, the access in flight
  // (mode 0 none, 1 strobe this cycle, 2 awaiting done), its owner and the
  // round-robin start position.
  bit          mv  [N];
  bit          mwe [N];
  logic [31:0] ma  [N];
  logic [31:0] md  [N];
  int          mode, g, ptr;
  bit          merr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int first_from(input int start, input bit live [N]);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (live[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < N; m++) begin
      mv[m] = 0; mwe[m] = 0; ma[m] = '0; md[m] = '0;
    end
    mode = 0; g = 0; ptr = 0; merr = 0;
  endtask

  task automatic clear_inputs();
    req_read_i  = '0;
    req_write_i = '0;
    flush_i     = 1'b0;
    dmem_done_i = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] xd;
    xd = '0;
    if (mode == 2 && dmem_done_i) xd[g] = 1'b1;
    chk("dmem_read", 32'(dmem_read_o), 32'(mode == 1 && !mwe[g]));
    chk("dmem_write", 32'(dmem_write_o), 32'(mode == 1 && mwe[g]));
    chk("busy", 32'(busy_o), 32'(mode != 0));
    chk("err", 32'(err_o), 32'(merr));
    chk("done_vec", 32'(req_done_o), 32'(xd));
    if (xd != '0) chk("rd_data", req_rd_data_o, dmem_rd_data_i);
    if (mode != 0) begin
      chk("dmem_addr", dmem_addr_o, ma[g]);
      chk("dmem_data", dmem_data_o, md[g]);
    end
  endtask

  task automatic model_step();
    bit keep [N];
    bit done;
    int nx;
    done = (mode == 2) && dmem_done_i;
    for (int m = 0; m < N; m++) begin
      keep[m] = mv[m];
      if (flush_i) keep[m] = (mode != 0 && m == g) ? mv[m] : 1'b0;
    end
    if (done) keep[g] = 0;
    if (mode == 0) begin
      nx = first_from(ptr, keep);
      if (nx >= 0) begin g = nx; mode = 1; end
    end else if (mode == 1) begin
      mode = 2;
    end else if (done) begin
      ptr = (g + 1) % N;
      nx  = first_from(ptr, keep);
      if (nx >= 0) begin g = nx; mode = 1; end
      else mode = 0;
    end
    for (int m = 0; m < N; m++) begin
      mv[m] = keep[m];
      if (req_read_i[m] || req_write_i[m]) begin
        if ((req_read_i[m] && req_write_i[m]) || keep[m]) merr = 1;
        else begin
          mv[m] = 1; mwe[m] = req_write_i[m]; ma[m] = req_addr_i[m]; md[m] = req_data_i[m];
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    check_outputs();
    model_step();
    @(posedge clk_i);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    #1;
    chk("rst_done", 32'(req_done_o), 0);
    chk("rst_rdata", req_rd_data_o, 0);
    chk("rst_read", 32'(dmem_read_o), 0);
    chk("rst_write", 32'(dmem_write_o), 0);
    chk("rst_addr", dmem_addr_o, 0);
    chk("rst_data", dmem_data_o, 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_err", 32'(err_o), 0);
    model_reset();
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset_i        = 1'b1;
    req_addr_i     = '0;
    req_data_i     = '0;
    dmem_rd_data_i = '0;
    clear_inputs();
    #2;
    do_reset();

    // Single read
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'h100;
    tick(); tick();
    #1; chk("t1_read", 32'(dmem_read_o), 1); chk("t1_addr", dmem_addr_o, 32'h100);
    tick(); tick(); tick();
    dmem_done_i = 1'b1; dmem_rd_data_i = 32'hDEADBEEF;
    #1; chk("t1_done", 32'(req_done_o), 32'b01); chk("t1_rdata", req_rd_data_o, 32'hDEADBEEF);
    tick();
    #1; chk("t1_idle", 32'(busy_o), 0);

    // Simultaneous requests from rr_ptr = 0
    do_reset();
    req_write_i[0] = 1'b1; req_addr_i[0] = 32'h200; req_data_i[0] = 32'h55;
    req_read_i[1]  = 1'b1; req_addr_i[1] = 32'h300;
    tick(); tick();
    #1; chk("t2_write", 32'(dmem_write_o), 1); chk("t2_waddr", dmem_addr_o, 32'h200);
    chk("t2_wdata", dmem_data_o, 32'h55);
    tick(); dmem_done_i = 1'b1; tick();
    #1; chk("t2_read", 32'(dmem_read_o), 1); chk("t2_raddr", dmem_addr_o, 32'h300);
    tick(); dmem_done_i = 1'b1;
    #1; chk("t2_done1", 32'(req_done_o), 32'b10);
    tick();

    // Fairness: req1 waits while req0 completes, req0 re-strobes right after
    req_read_i = 2'b11; req_addr_i[0] = 32'h500; req_addr_i[1] = 32'h600;
    tick(); tick();
    #1; chk("t3_first", dmem_addr_o, 32'h500);
    tick(); dmem_done_i = 1'b1; tick();
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'h700;
    #1; chk("t3_req1_next", dmem_addr_o, 32'h600); chk("t3_read", 32'(dmem_read_o), 1);
    tick(); dmem_done_i = 1'b1;
    #1; chk("t3_done1", 32'(req_done_o), 32'b10);
    tick();
    #1; chk("t3_req0_last", dmem_addr_o, 32'h700);
    tick(); dmem_done_i = 1'b1; tick();

    // Flush while req0 in flight and req1 pending
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'h800;
    tick(); tick();
    req_read_i[1] = 1'b1; req_addr_i[1] = 32'h900;
    tick();
    flush_i = 1'b1; tick();
    dmem_done_i = 1'b1;
    #1; chk("t4_done0", 32'(req_done_o), 32'b01);
    tick();
    for (int c = 0; c < 6; c++) begin
      dmem_done_i = 1'b1;
      #1; chk("t4_no_issue", 32'(dmem_read_o), 0); chk("t4_no_done1", 32'(req_done_o[1]), 0);
      tick();
    end

    // Protocol error: repeat strobe on an occupied slot
    do_reset();
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'h100;
    tick();
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'h400;
    tick();
    #1; chk("t6_err", 32'(err_o), 1); chk("t6_addr", dmem_addr_o, 32'h100);
    tick(); dmem_done_i = 1'b1; tick(); tick();
    #1; chk("t6_err_sticky", 32'(err_o), 1);

    // Asynchronous reset mid-WAIT
    do_reset();
    req_read_i[0] = 1'b1; req_addr_i[0] = 32'hA00;
    tick(); tick(); tick();
    #2;
    do_reset();
    dmem_done_i = 1'b1;
    #1; chk("t5_no_done", 32'(req_done_o), 0);
    tick();

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (cyc % 300 == 299) do_reset();
      for (int m = 0; m < N; m++) begin
        int r;
        r = $urandom_range(0, 99);
        req_read_i[m]  = (r < 15) || (r >= 30 && r < 32);
        req_write_i[m] = (r >= 15 && r < 32);
        req_addr_i[m]  = $urandom;
        req_data_i[m]  = $urandom;
      end
      dmem_done_i    = ($urandom_range(0, 99) < 35);
      dmem_rd_data_i = $urandom;
      flush_i        = (mode != 0) && ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
